// File: rtl/alu_capture_stage.sv
// -----------------------------------------------------------------------------
// alu_capture_stage
//
// Capture and sequencing stage that sits behind the 8-bit ripple-CLA adder.
// A start request enables the adder and drives its add/subtract select, then
// waits until the adder's ready has been high for SETTLE consecutive cycles.
// At that point the sum is registered into the accumulator and the Z/C/N/V
// flags are derived. If ready does not settle within TIMEOUT cycles, a sticky
// error is raised instead.
//
// Parameters:
//   SETTLE   consecutive ready-high cycles required before capture (1..7)
//   TIMEOUT  maximum cycles spent waiting before error (SETTLE..255)
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, sub           operation request and add(0)/subtract(1) select
//   clr                  clear of acc, flags and err (IDLE only)
//   a_msb, b_msb         operand sign bits, used for overflow detection
//   sum_in, carry_in     adder result and carry-out
//   adder_ready          adder result-valid indication
//   adder_en, adder_sub  adder enable and carry-in/subtract select
//   acc                  captured result
//   flag_z/c/n/v         result flags
//   busy, done           handshake: busy in ARM/WAIT, done one-cycle pulse
//   err                  sticky timeout error
// -----------------------------------------------------------------------------
module alu_capture_stage #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sub,
  input  logic       clr,
  input  logic       a_msb,
  input  logic       b_msb,
  input  logic [7:0] sum_in,
  input  logic       carry_in,
  input  logic       adder_ready,
  output logic       adder_en,
  output logic       adder_sub,
  output logic [7:0] acc,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_n,
  output logic       flag_v,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] SETTLE_LAST  = 3'(SETTLE - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [2:0] rdy_cnt;
  logic [7:0] wait_cnt;

  // Capture fires on the SETTLE-th consecutive ready-high edge in WAIT; it
  // is evaluated ahead of the timeout so it wins when both land together.
  logic capture;
  logic timed_out;
  logic v_next;

  assign capture   = (state == S_WAIT) && adder_ready && (rdy_cnt == SETTLE_LAST);
  assign timed_out = (wait_cnt == TIMEOUT_LAST);

  // Signed overflow: operands (B after optional inversion) agree in sign but
  // the result's sign differs from A.
  assign v_next = (a_msb == (b_msb ^ adder_sub)) && (sum_in[7] != a_msb);

  // Handshake outputs are pure decodes of the state register.
  assign busy     = (state == S_ARM) || (state == S_WAIT);
  assign adder_en = busy;
  assign done     = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rdy_cnt   <= '0;
      wait_cnt  <= '0;
      adder_sub <= 1'b0;
      acc       <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr) begin
            // Clear wins over a simultaneous start; no operation is launched.
            acc    <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
            err    <= 1'b0;
          end else if (start) begin
            adder_sub <= sub;
            state     <= S_ARM;
          end
        end

        S_ARM: begin
          // Ready is deliberately ignored here so a level left over from the
          // previous operation can never count toward settling.
          rdy_cnt  <= '0;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (capture) begin
            acc    <= sum_in;
            flag_z <= (sum_in == 8'h00);
            flag_n <= sum_in[7];
            flag_c <= carry_in ^ adder_sub;
            flag_v <= v_next;
            state  <= S_DONE;
          end else begin
            if (adder_ready) begin
              rdy_cnt <= rdy_cnt + 3'd1;
            end else begin
              rdy_cnt <= '0;
            end
            if (timed_out) begin
              err   <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_capture_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_capture_stage
//
// Directed self-checking bench for alu_capture_stage (SETTLE=2, TIMEOUT=15).
// Each task drives one scenario and compares outputs against hand-computed
// values. Inputs change 1 ns after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_alu_capture_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic       clr;
  logic       a_msb;
  logic       b_msb;
  logic [7:0] sum_in;
  logic       carry_in;
  logic       adder_ready;
  logic       adder_en;
  logic       adder_sub;
  logic [7:0] acc;
  logic       flag_z;
  logic       flag_c;
  logic       flag_n;
  logic       flag_v;
  logic       busy;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  alu_capture_stage #(.SETTLE(2), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sub         (sub),
    .clr         (clr),
    .a_msb       (a_msb),
    .b_msb       (b_msb),
    .sum_in      (sum_in),
    .carry_in    (carry_in),
    .adder_ready (adder_ready),
    .adder_en    (adder_en),
    .adder_sub   (adder_sub),
    .acc         (acc),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .flag_n      (flag_n),
    .flag_v      (flag_v),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for one edge; returns 1 ns after the start edge (ARM).
  task automatic do_start(input logic sub_v);
    start = 1'b1;
    sub   = sub_v;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done; cyc = edges after the start edge, bcnt = busy cycles.
  task automatic wait_done(input int limit, output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < limit) begin
      tick();
      cyc++;
      if (busy) bcnt++;
    end
  endtask

  task automatic set_adder(input logic [7:0] s, input logic c, input logic am,
                           input logic bm, input logic rdy);
    sum_in      = s;
    carry_in    = c;
    a_msb       = am;
    b_msb       = bm;
    adder_ready = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; sub = 1'b0; clr = 1'b0;
    set_adder(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    checks++;
    if ({acc, flag_z, flag_c, flag_n, flag_v, busy, done, adder_en, adder_sub, err} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs got acc=%0h z%0b c%0b n%0b v%0b busy%0b done%0b en%0b sub%0b err%0b exp all 0",
               acc, flag_z, flag_c, flag_n, flag_v, busy, done, adder_en, adder_sub, err);
    end
    #3 rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || acc !== 8'h00) begin
      failures++;
      $display("FAIL reset_release got busy=%0b done=%0b acc=%0h exp 0 0 00", busy, done, acc);
    end
  endtask

  task automatic test_add();
    int cyc, bcnt;
    set_adder(8'h9B, 1'b0, 1'b0, 1'b0, 1'b1);
    do_start(1'b0);
    checks++;
    if (adder_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL add_arm got en=%0b busy=%0b exp 1 1", adder_en, busy);
    end
    wait_done(40, cyc, bcnt);
    checks++;
    if (cyc !== 3) begin
      failures++;
      $display("FAIL add_latency got %0d exp 3", cyc);
    end
    checks++;
    if (bcnt !== 3) begin
      failures++;
      $display("FAIL add_busy_cycles got %0d exp 3", bcnt);
    end
    checks++;
    if (acc !== 8'h9B || {flag_z, flag_c, flag_n, flag_v} !== 4'b0011 || err !== 1'b0) begin
      failures++;
      $display("FAIL add_result got acc=%0h zcnv=%b err=%0b exp 9b 0011 0",
               acc, {flag_z, flag_c, flag_n, flag_v}, err);
    end
    checks++;
    if (adder_en !== 1'b0) begin
      failures++;
      $display("FAIL add_done_en got %0b exp 0", adder_en);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL add_done_pulse got done=%0b busy=%0b exp 0 0", done, busy);
    end
  endtask

  task automatic test_sub();
    int cyc, bcnt;
    // 5 - 5: no borrow, zero result.
    set_adder(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    do_start(1'b1);
    checks++;
    if (adder_sub !== 1'b1) begin
      failures++;
      $display("FAIL sub_select got %0b exp 1", adder_sub);
    end
    wait_done(40, cyc, bcnt);
    checks++;
    if (cyc !== 3 || acc !== 8'h00 || {flag_z, flag_c, flag_n, flag_v} !== 4'b1000) begin
      failures++;
      $display("FAIL sub_equal got cyc=%0d acc=%0h zcnv=%b exp 3 00 1000",
               cyc, acc, {flag_z, flag_c, flag_n, flag_v});
    end
    tick();
    // 4 - 5: borrow, negative result.
    set_adder(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    do_start(1'b1);
    wait_done(40, cyc, bcnt);
    checks++;
    if (cyc !== 3 || acc !== 8'hFF || {flag_z, flag_c, flag_n, flag_v} !== 4'b0110) begin
      failures++;
      $display("FAIL sub_borrow got cyc=%0d acc=%0h zcnv=%b exp 3 ff 0110",
               cyc, acc, {flag_z, flag_c, flag_n, flag_v});
    end
    tick();
  endtask

  task automatic test_ready_glitch();
    logic [3:0] pat;
    logic [3:0] done_seen;
    pat = 4'b1101;  // applied LSB first: 1,0,1,1
    done_seen = '0;
    // Ready already high while in ARM must not count.
    set_adder(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    do_start(1'b0);
    tick();  // ARM -> WAIT edge
    for (int i = 0; i < 4; i++) begin
      adder_ready = pat[i];
      tick();
      done_seen[i] = done;
    end
    checks++;
    if (done_seen !== 4'b1000) begin
      failures++;
      $display("FAIL glitch_done_timing got %b exp 1000", done_seen);
    end
    checks++;
    if (acc !== 8'h3C || {flag_z, flag_c, flag_n, flag_v} !== 4'b0000) begin
      failures++;
      $display("FAIL glitch_result got acc=%0h zcnv=%b exp 3c 0000",
               acc, {flag_z, flag_c, flag_n, flag_v});
    end
    tick();
  endtask

  task automatic test_timeout();
    int cyc, bcnt;
    set_adder(8'h77, 1'b1, 1'b1, 1'b1, 1'b0);
    do_start(1'b0);
    wait_done(40, cyc, bcnt);
    checks++;
    if (cyc !== 16 || err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_latency got cyc=%0d err=%0b exp 16 1", cyc, err);
    end
    checks++;
    if (acc !== 8'h3C || {flag_z, flag_c, flag_n, flag_v} !== 4'b0000) begin
      failures++;
      $display("FAIL timeout_acc_kept got acc=%0h zcnv=%b exp 3c 0000",
               acc, {flag_z, flag_c, flag_n, flag_v});
    end
    tick();
    // A good operation afterwards leaves err set.
    set_adder(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    do_start(1'b0);
    wait_done(40, cyc, bcnt);
    checks++;
    if (acc !== 8'h01 || err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_err_sticky got acc=%0h err=%0b exp 01 1", acc, err);
    end
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (err !== 1'b0 || acc !== 8'h00 || {flag_z, flag_c, flag_n, flag_v} !== 4'b0000) begin
      failures++;
      $display("FAIL clr_clears got err=%0b acc=%0h zcnv=%b exp 0 00 0000",
               err, acc, {flag_z, flag_c, flag_n, flag_v});
    end
  endtask

  task automatic test_reset_mid_wait();
    int cyc, bcnt;
    // Give acc a nonzero value first.
    set_adder(8'h42, 1'b1, 1'b0, 1'b0, 1'b1);
    do_start(1'b0);
    wait_done(40, cyc, bcnt);
    tick();
    adder_ready = 1'b0;
    do_start(1'b1);
    tick();
    tick();  // now in WAIT
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({acc, flag_z, flag_c, flag_n, flag_v, busy, done, adder_en, adder_sub, err} !== 17'h0) begin
      failures++;
      $display("FAIL reset_mid_wait got acc=%0h zcnv=%b busy%0b done%0b en%0b sub%0b err%0b exp all 0",
               acc, {flag_z, flag_c, flag_n, flag_v}, busy, done, adder_en, adder_sub, err);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    set_adder(8'h25, 1'b0, 1'b0, 1'b0, 1'b1);
    do_start(1'b0);
    wait_done(40, cyc, bcnt);
    checks++;
    if (cyc !== 3 || acc !== 8'h25 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_recover got cyc=%0d acc=%0h err=%0b exp 3 25 0", cyc, acc, err);
    end
    tick();
  endtask

  task automatic test_protocol();
    int dcount;
    // start held through ARM and WAIT with a different sub must be ignored.
    set_adder(8'h10, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1; sub = 1'b0;
    tick();
    sub = 1'b1;
    tick();
    tick();
    start = 1'b0;
    dcount = done ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dcount++;
    end
    checks++;
    if (dcount !== 1 || adder_sub !== 1'b0 || acc !== 8'h10) begin
      failures++;
      $display("FAIL start_while_busy got dones=%0d sub=%0b acc=%0h exp 1 0 10", dcount, adder_sub, acc);
    end
    // clr together with start: cleared, nothing launched.
    clr = 1'b1; start = 1'b1; sub = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || acc !== 8'h00 || adder_sub !== 1'b0) begin
      failures++;
      $display("FAIL clr_with_start got busy=%0b acc=%0h sub=%0b exp 0 00 0", busy, acc, adder_sub);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL clr_with_start_idle got busy=%0b done=%0b exp 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int first, second, n;
    first = -1; second = -1; n = 0;
    set_adder(8'h80, 1'b0, 1'b1, 1'b1, 1'b1);
    start = 1'b1; sub = 1'b0;
    for (int i = 1; i <= 20 && second < 0; i++) begin
      tick();
      if (done) begin
        if (first < 0) first = i;
        else second = i;
      end
      n = i;
    end
    start = 1'b0;
    checks++;
    if (first < 0 || second < 0 || (second - first) !== 5) begin
      failures++;
      $display("FAIL back_to_back_spacing got first=%0d second=%0d after %0d cycles exp spacing 5",
               first, second, n);
    end
    // 0x80 + 0x80: carry out, zero result, signed overflow.
    carry_in = 1'b1; sum_in = 8'h00;
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++;
    if (acc !== 8'h00 || {flag_z, flag_c, flag_n, flag_v} !== 4'b1101) begin
      failures++;
      $display("FAIL add_overflow got acc=%0h zcnv=%b exp 00 1101",
               acc, {flag_z, flag_c, flag_n, flag_v});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ready_glitch();
    test_timeout();
    test_reset_mid_wait();
    test_protocol();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
